ibex_rvfi_trace_buffer: RTL

// Synthesisable on-chip trace capture for ibex_top: records retired-instruction records taken

---
 rtl/ibex_rvfi_trace_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// rtl/ibex_rvfi_trace_buffer.sv - RVFI retirement trace buffer with arm/trigger/freeze capture
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth      = 16,
  parameter bit          CaptureMem = 1'b0,
  localparam int unsigned CW        = $clog2(Depth) + 1,
  localparam int unsigned EntryW    = 103 + (CaptureMem ? 40 : 0)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              arm_i,
  input  logic              mode_i,
  input  logic              trig_pc_en_i,
  input  logic [31:0]       trig_pc_i,
  input  logic              trig_trap_en_i,
  input  logic [CW-1:0]     post_trig_i,
  input  logic              rvfi_valid_i,
  input  logic [31:0]       rvfi_pc_rdata_i,
  input  logic [31:0]       rvfi_insn_i,
  input  logic [4:0]        rvfi_rd_addr_i,
  input  logic [31:0]       rvfi_rd_wdata_i,
  input  logic              rvfi_trap_i,
  input  logic              rvfi_intr_i,
  input  logic [31:0]       rvfi_mem_addr_i,
  input  logic [3:0]        rvfi_mem_rmask_i,
  input  logic [3:0]        rvfi_mem_wmask_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [EntryW-1:0] rd_data_o,
  output logic [1:0]        state_o,
  output logic              triggered_o,
  output logic [CW-1:0]     count_o,
  output logic [15:0]       overflow_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [CW-1:0] DepthCnt = CW'(Depth);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, FROZEN = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d, rem_q, rem_d;
  logic [15:0]       ovf_q, ovf_d;
  logic              trig_q, trig_d;
  logic              we, store, pop, full, hit;
  logic [EntryW-1:0] wr_data;
  logic [EntryW-1:0] mem_q [Depth];

  generate
    if (CaptureMem) begin : g_mem
      assign wr_data = {rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, rvfi_pc_rdata_i,
                        rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_trap_i, rvfi_intr_i};
    end else begin : g_nomem
      logic unused_mem;
      assign unused_mem = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i};
      assign wr_data = {rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
                        rvfi_trap_i, rvfi_intr_i};
    end
  endgenerate

  assign hit  = rvfi_valid_i & ((trig_pc_en_i & (rvfi_pc_rdata_i == trig_pc_i)) |
                                (trig_trap_en_i & rvfi_trap_i));
  assign pop  = rd_valid_o & rd_ready_i;
  assign full = (count_q == DepthCnt);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    trig_d  = trig_q;
    rem_d   = rem_q;
    store   = 1'b0;
    we      = 1'b0;
    if (arm_i) begin
      state_d = ARMED;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = '0;
      trig_d  = 1'b0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (hit) begin
            trig_d = 1'b1;
            if (post_trig_i == '0) begin
              state_d = FROZEN;
            end else if (post_trig_i == CW'(1)) begin
              store   = 1'b1;
              state_d = FROZEN;
            end else begin
              store   = 1'b1;
              rem_d   = post_trig_i - CW'(1);
              state_d = CAPTURE;
            end
          end else begin
            store = rvfi_valid_i;
          end
        end
        CAPTURE: begin
          if (rvfi_valid_i) begin
            store = 1'b1;
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) state_d = FROZEN;
          end
        end
        default: ;
      endcase

      // The drop/overwrite decision uses the pre-pop count. In ring mode a full write moves the
      // head by exactly one whether or not a pop happens in the same cycle.
      if (store && full && !mode_i) begin
        if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        if (pop) begin
          rptr_d  = rptr_q + AW'(1);
          count_d = count_q - CW'(1);
        end
      end else if (store && full) begin
        we     = 1'b1;
        wptr_d = wptr_q + AW'(1);
        rptr_d = rptr_q + AW'(1);
      end else if (store) begin
        we     = 1'b1;
        wptr_d = wptr_q + AW'(1);
        if (pop) rptr_d = rptr_q + AW'(1);
        else     count_d = count_q + CW'(1);
      end else if (pop) begin
        rptr_d  = rptr_q + AW'(1);
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      trig_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      trig_q  <= trig_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q] <= wr_data;
  end

  assign rd_valid_o  = (count_q != '0);
  assign rd_data_o   = mem_q[rptr_q];
  assign state_o     = state_q;
  assign triggered_o = trig_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;

endmodule
